// File: rtl/jam_pkg.sv
// rtl/jam_pkg.sv - shared sizes, state encoding and helpers for the JAM permutation sequencer
package jam_pkg;

  localparam int N_DEF     = 8;
  localparam int IDX_W_DEF = 3;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {IDLE, EMIT, SCAN, SWAP, REV, DONE} state_t;

  typedef logic [N_DEF-1:0][IDX_W_DEF-1:0] perm_t;

  // Worker k -> job k, packed with worker 0 in the least significant field.
  function automatic logic [63:0] identity_perm(input int n, input int idx_w);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r = r | (64'(k) << (k * idx_w));
    return r;
  endfunction

endpackage

// File: rtl/jam_perm_gen_if.sv
// rtl/jam_perm_gen_if.sv - permutation stream and control bundle between sequencer and evaluator
interface jam_perm_gen_if
  import jam_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic               start;
  logic [N*IDX_W-1:0] perm;
  logic               perm_valid;
  logic               perm_ready;
  logic               perm_last;
  logic [CNT_W-1:0]   perm_idx;
  logic               busy;
  logic               done;

  modport master (
    input  start, perm_ready,
    output perm, perm_valid, perm_last, perm_idx, busy, done
  );

  modport slave (
    output start, perm_ready,
    input  perm, perm_valid, perm_last, perm_idx, busy, done
  );

endinterface

// File: rtl/jam_pivot_find.sv
// rtl/jam_pivot_find.sv - combinational pivot / swap-index search for next-permutation
module jam_pivot_find
  import jam_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic [N*IDX_W-1:0] perm,
  output logic [IDX_W-1:0]   pivot,
  output logic [IDX_W-1:0]   swap_idx,
  output logic               found
);

  logic [IDX_W-1:0] p [N];
  logic [IDX_W-1:0] pivot_val;

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign p[k] = perm[k*IDX_W +: IDX_W];
  end

  // Later hits overwrite earlier ones, so the largest qualifying index wins.
  always_comb begin
    pivot = '0;
    found = 1'b0;
    for (int i = 0; i < N - 1; i++) begin
      if (p[i] < p[i+1]) begin
        pivot = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    pivot_val = '0;
    for (int k = 0; k < N; k++) begin
      if (IDX_W'(k) == pivot) pivot_val = p[k];
    end
  end

  always_comb begin
    swap_idx = '0;
    for (int j = 0; j < N; j++) begin
      if ((IDX_W'(j) > pivot) && (p[j] > pivot_val)) swap_idx = IDX_W'(j);
    end
  end

endmodule

// File: rtl/jam_perm_gen.sv
// rtl/jam_perm_gen.sv - lexicographic permutation sequencer feeding the JAM cost evaluator
module jam_perm_gen
  import jam_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic           CLK,
  input  logic           RST,
  jam_perm_gen_if.master bus
);

  localparam logic [63:0]        IDENT_W = identity_perm(N, IDX_W);
  localparam logic [N*IDX_W-1:0] IDENT   = IDENT_W[N*IDX_W-1:0];

  state_t                  state;
  logic [N-1:0][IDX_W-1:0] perm_q;
  logic [N-1:0][IDX_W-1:0] rev_perm;
  logic [IDX_W-1:0]        pivot, swap_idx, piv_q, swp_q;
  logic                    found;
  logic                    valid_q, busy_q, done_q;
  logic [CNT_W-1:0]        idx_q;

  jam_pivot_find #(.N(N), .IDX_W(IDX_W)) u_find (
    .perm     (perm_q),
    .pivot    (pivot),
    .swap_idx (swap_idx),
    .found    (found)
  );

  // Suffix after the pivot mirrored in place: position k takes N + pivot - k.
  always_comb begin
    rev_perm = perm_q;
    for (int k = 0; k < N; k++) begin
      for (int m = 0; m < N; m++) begin
        if ((k > int'(piv_q)) && (m == N + int'(piv_q) - k)) rev_perm[k] = perm_q[m];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      perm_q  <= IDENT;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      piv_q   <= '0;
      swp_q   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state   <= EMIT;
            perm_q  <= IDENT;
            idx_q   <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        EMIT: begin
          if (valid_q && bus.perm_ready) begin
            valid_q <= 1'b0;
            if (!found) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          piv_q <= pivot;
          swp_q <= swap_idx;
          state <= SWAP;
        end
        SWAP: begin
          perm_q[piv_q] <= perm_q[swp_q];
          perm_q[swp_q] <= perm_q[piv_q];
          state         <= REV;
        end
        REV: begin
          perm_q  <= rev_perm;
          idx_q   <= idx_q + CNT_W'(1);
          valid_q <= 1'b1;
          state   <= EMIT;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.perm       = perm_q;
  assign bus.perm_valid = valid_q;
  assign bus.perm_last  = ~found;
  assign bus.perm_idx   = idx_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
